// File: rtl/drum_voice_mixer.sv
// drum_voice_mixer: pad-triggered sample playback with a saturating mix stage.
// Each pad owns one voice that walks its own region of the shared sample ROM.
// Once per frame the active voices are summed, clamped to the sample width
// and pushed to the Audio_Controller output FIFO.
// Optional build macro DRUM_MIX_ATTEN_EN adds a 2-bit 'atten' input that
// arithmetically right-shifts the mix before it is clamped.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | apply pending pad triggers, wait for enable/FIFO space/voice
// READ   | walk voices 0..N-1 through the ROM, accumulate one cycle late
// SAT    | optional attenuation, clamp mix, register it on the outputs
// WRITE  | push when FIFO allows, advance or retire every active voice
module drum_voice_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int REGION_W   = 12,
    parameter int VOICE_LEN  = 2839,
    parameter int SAMPLE_W   = 32
) (
    input  logic                                    CLOCK_50,
    input  logic                                    reset,
    input  logic [NUM_VOICES-1:0]                   key_n,
    input  logic                                    enable,
    output logic [REGION_W+$clog2(NUM_VOICES)-1:0]  rom_addr,
    input  logic [SAMPLE_W-1:0]                     rom_q,
    input  logic                                    audio_out_allowed,
`ifdef DRUM_MIX_ATTEN_EN
    input  logic [1:0]                              atten,
`endif
    output logic                                    write_audio_out,
    output logic [SAMPLE_W-1:0]                     left_channel_audio_out,
    output logic [SAMPLE_W-1:0]                     right_channel_audio_out,
    output logic [NUM_VOICES-1:0]                   voice_busy
);

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int ACC_W  = SAMPLE_W + VIDX_W;
    localparam int CNT_W  = VIDX_W + 1;

    localparam logic [REGION_W-1:0]     LAST_OFF = REGION_W'(VOICE_LEN - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(NUM_VOICES);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(VIDX_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(VIDX_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_SAT,
        ST_WRITE
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [SAMPLE_W-1:0]        sample_q, sample_d;
    logic [NUM_VOICES-1:0]      active_q, active_d;
    logic [NUM_VOICES-1:0]      pending_q, pending_d;
    logic [REGION_W-1:0]        offset_q [NUM_VOICES];
    logic [REGION_W-1:0]        offset_d [NUM_VOICES];

    logic [NUM_VOICES-1:0]      key_s1_q, key_s1_d;
    logic [NUM_VOICES-1:0]      key_s2_q, key_s2_d;
    logic [NUM_VOICES-1:0]      key_prev_q, key_prev_d;
    logic [NUM_VOICES-1:0]      key_fall;

    logic [VIDX_W-1:0]          rd_idx;
    logic [VIDX_W-1:0]          acc_idx;
    logic signed [ACC_W-1:0]    sat_in;

    // Two-flop synchronizer plus a delayed copy for press (falling-edge) detection.
    always_comb begin
        key_s1_d   = key_n;
        key_s2_d   = key_s1_q;
        key_prev_d = key_s2_q;
        key_fall   = key_prev_q & ~key_s2_q;
    end

    // Synchronizer flops come out of reset as "released" so no press is invented.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            key_prev_q <= '1;
        end else begin
            key_s1_q   <= key_s1_d;
            key_s2_q   <= key_s2_d;
            key_prev_q <= key_prev_d;
        end
    end

    // Frame sequencer: next state, voice bookkeeping, ROM walk, mix and clamp.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        sample_d        = sample_q;
        active_d        = active_q;
        offset_d        = offset_q;
        pending_d       = pending_q | key_fall;
        write_audio_out = 1'b0;
        rom_addr        = '0;
        rd_idx          = cnt_q[VIDX_W-1:0];
        // Wraps to the last voice when cnt_q == NUM_VOICES, which is exactly
        // the voice whose ROM word lands in that final READ cycle.
        acc_idx         = cnt_q[VIDX_W-1:0] - VIDX_W'(1);
`ifdef DRUM_MIX_ATTEN_EN
        sat_in          = acc_q >>> atten;
`else
        sat_in          = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Presses latched earlier take effect now; presses seen this
                // very cycle stay pending for the next visit to IDLE.
                active_d  = active_q | pending_q;
                pending_d = key_fall;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (pending_q[v]) begin
                        offset_d[v] = '0;
                    end
                end
                if (enable && audio_out_allowed && (|(active_q | pending_q))) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end

            ST_READ: begin
                if (cnt_q != CNT_LAST) begin
                    rom_addr = {rd_idx, offset_q[rd_idx]};
                end
                if (cnt_q != '0 && active_q[acc_idx]) begin
                    acc_d = acc_q + {{VIDX_W{rom_q[SAMPLE_W-1]}}, rom_q};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SAT: begin
                if (sat_in > SAT_MAX) begin
                    sample_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
                end else if (sat_in < SAT_MIN) begin
                    sample_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
                end else begin
                    sample_d = sat_in[SAMPLE_W-1:0];
                end
                state_d = ST_WRITE;
            end

            ST_WRITE: begin
                if (audio_out_allowed) begin
                    write_audio_out = 1'b1;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (active_q[v]) begin
                            if (offset_q[v] == LAST_OFF) begin
                                active_d[v] = 1'b0;
                            end else begin
                                offset_d[v] = offset_q[v] + REGION_W'(1);
                            end
                        end
                    end
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and voice state registers.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            sample_q  <= '0;
            active_q  <= '0;
            pending_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                offset_q[v] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sample_q  <= sample_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            offset_q  <= offset_d;
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign voice_busy              = active_q;

endmodule

// File: tb/tb_drum_voice_mixer.sv
// Bench for drum_voice_mixer: frame-level voice model, ROM model, randomized
// FIFO back-pressure / enable, and directed pad scenarios.
module tb_drum_voice_mixer;

    localparam int NV = 4;
    localparam int RW = 12;
    localparam int VL = 2839;
    localparam int SW = 32;
    localparam int AW = RW + 2;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic [NV-1:0]   key_n;
    logic            enable;
    logic [AW-1:0]   rom_addr;
    logic [SW-1:0]   rom_q;
    logic            audio_out_allowed;
    logic            write_audio_out;
    logic [SW-1:0]   left_out;
    logic [SW-1:0]   right_out;
    logic [NV-1:0]   voice_busy;
`ifdef DRUM_MIX_ATTEN_EN
    logic [1:0]      atten = 2'd0;
`endif

    always #5 CLOCK_50 = ~CLOCK_50;

    drum_voice_mixer dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .key_n                   (key_n),
        .enable                  (enable),
        .rom_addr                (rom_addr),
        .rom_q                   (rom_q),
        .audio_out_allowed       (audio_out_allowed),
`ifdef DRUM_MIX_ATTEN_EN
        .atten                   (atten),
`endif
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .voice_busy              (voice_busy)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rom_mode = 0;
    int unsigned rom_seed = 32'h1234_5678;

    bit          m_active [NV];
    int          m_off    [NV];
    int          n_writes = 0;
    logic [31:0] last_written = '0;
    logic [31:0] first_val = '0;
    bit          capture_first = 0;

    function automatic logic [31:0] rom_fn(int v, int off);
        int unsigned h;
        case (rom_mode)
            0: return 32'(off + 1 + v * 4096);
            1: case (v)
                   0: return 32'(100);
                   1: return 32'(7);
                   2: return 32'(-30);
                   default: return 32'(-9);
               endcase
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: begin
                h = (32'(off) * 32'h9E37_79B1) ^ (32'(v + 1) * 32'h85EB_CA6B) ^ rom_seed;
                h = h ^ (h >> 15);
                return h;
            end
        endcase
    endfunction

    // ROM: data appears one cycle after the address.
    always @(posedge CLOCK_50) begin
        rom_q <= rom_fn(int'(rom_addr[AW-1:RW]), int'(rom_addr[RW-1:0]));
    end

    function automatic logic [31:0] exp_sample();
        longint s = 0;
        logic signed [31:0] r;
        for (int v = 0; v < NV; v++) begin
            if (m_active[v]) begin
                r = rom_fn(v, m_off[v]);
                s += r;
            end
        end
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
        return s[31:0];
    endfunction

    function automatic logic [NV-1:0] model_bits();
        logic [NV-1:0] b = '0;
        for (int v = 0; v < NV; v++) b[v] = m_active[v];
        return b;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_active[v] = 0;
            m_off[v]    = 0;
        end
    endtask

    // Every push is checked against the frame model, then the model steps.
    always @(negedge CLOCK_50) begin
        if (reset === 1'b1 && write_audio_out === 1'b1) begin
            check("strobe_allowed", {63'b0, audio_out_allowed}, 64'd1);
            check("left_eq_right", right_out, left_out);
            check("write_has_voice", {63'b0, |model_bits()}, 64'd1);
            check("busy_at_write", voice_busy, model_bits());
            check("sample", left_out, exp_sample());
            last_written = left_out;
            if (capture_first) begin
                first_val     = left_out;
                capture_first = 0;
            end
            n_writes++;
            for (int v = 0; v < NV; v++) begin
                if (m_active[v]) begin
                    if (m_off[v] == VL - 1) m_active[v] = 0;
                    else m_off[v]++;
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        key_n = '1;
        enable = 1'b0;
        audio_out_allowed = 1'b0;
        tick(3);
        check("rst_write", {63'b0, write_audio_out}, 64'd0);
        check("rst_left", left_out, 64'd0);
        check("rst_right", right_out, 64'd0);
        check("rst_busy", voice_busy, 64'd0);
        check("rst_addr", rom_addr, 64'd0);
        model_clear();
        reset = 1'b1;
        tick(2);
    endtask

    // Finish any frame in flight, then press the pads in mask while idle.
    task automatic quiesce_press(logic [NV-1:0] mask);
        enable = 1'b0;
        audio_out_allowed = 1'b1;
        tick(14);
        key_n = key_n | mask;
        tick(4);
        key_n = key_n & ~mask;
        tick(6);
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) begin
                m_active[v] = 1;
                m_off[v]    = 0;
            end
        end
        check("busy_after_press", voice_busy, model_bits());
        enable = 1'b1;
    endtask

    task automatic run_frames(int n, bit rnd);
        int start = n_writes;
        int budget = n * 40 + 200;
        while (n_writes - start < n && budget > 0) begin
            if (rnd) begin
                audio_out_allowed = ($urandom_range(3) != 0);
                enable            = ($urandom_range(7) != 0);
            end else begin
                audio_out_allowed = 1'b1;
                enable            = 1'b1;
            end
            tick(1);
            budget--;
        end
        if (budget == 0) check("run_timeout", n_writes - start, n);
        audio_out_allowed = 1'b1;
        enable = 1'b1;
    endtask

    task automatic wait_write(string name);
        int start = n_writes;
        int budget = 100;
        audio_out_allowed = 1'b1;
        enable = 1'b1;
        while (n_writes == start && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check(name, n_writes - start, 1);
    endtask

    initial begin
        int mark;
        int budget;
        reset = 1'b0;
        key_n = '1;
        enable = 1'b0;
        audio_out_allowed = 1'b0;
        model_clear();

        // Single voice, ramp content, key held low the whole time.
        do_reset();
        rom_mode = 0;
        quiesce_press(4'b0001);
        mark = n_writes;
        capture_first = 1;
        budget = VL * 10 + 200;
        while (|model_bits() && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) check("t1_timeout", {63'b0, |model_bits()}, 64'd0);
        check("t1_first", first_val, 64'd1);
        check("t1_last", last_written, 64'd2839);
        check("t1_count", n_writes - mark, 64'd2839);
        tick(60);
        check("t1_no_extra", n_writes - mark, 64'd2839);
        check("t1_busy_done", voice_busy, 64'd0);

        // Voices 0 and 2: 100 + (-30).
        do_reset();
        rom_mode = 1;
        quiesce_press(4'b0101);
        run_frames(200, 1);
        check("t2_mix", last_written, 64'd70);
        check("t2_busy", voice_busy, 64'h5);

        // Saturation both ways.
        do_reset();
        rom_mode = 2;
        quiesce_press(4'b1111);
        run_frames(30, 1);
        check("t3_pos_sat", last_written, 64'h7FFF_FFFF);
        do_reset();
        rom_mode = 3;
        quiesce_press(4'b1111);
        run_frames(30, 1);
        check("t4_neg_sat", last_written, 64'h8000_0000);

        // FIFO full while a frame is being read.
        wait_write("t5_wait");
        tick(1);
        audio_out_allowed = 1'b0;
        mark = n_writes;
        tick(15);
        check("t5_hold_no_strobe", n_writes - mark, 64'd0);
        check("t5_hold_write_low", {63'b0, write_audio_out}, 64'd0);
        audio_out_allowed = 1'b1;
        tick(3);
        check("t5_one_strobe", n_writes - mark, 64'd1);

        // Retrigger voice 1 around offset 500.
        do_reset();
        rom_mode = 0;
        quiesce_press(4'b0010);
        budget = 20000;
        while (m_off[1] < 500 && budget > 0) begin
            audio_out_allowed = ($urandom_range(3) != 0);
            tick(1);
            budget--;
        end
        if (budget == 0) check("t6_timeout", m_off[1], 500);
        quiesce_press(4'b0010);
        capture_first = 1;
        run_frames(3, 0);
        check("t6_restart", first_val, 64'd4097);

        // Random content, random pad sets, random back-pressure.
        do_reset();
        rom_mode = 4;
        rom_seed = $urandom;
        for (int r = 0; r < 6; r++) begin
            quiesce_press(4'($urandom_range(1, 15)));
            run_frames($urandom_range(20, 60), 1);
        end

        // Reset in the middle of READ.
        wait_write("t8_wait");
        tick(2);
        reset = 1'b0;
        key_n = '1;
        #1;
        check("t8_write", {63'b0, write_audio_out}, 64'd0);
        check("t8_left", left_out, 64'd0);
        check("t8_right", right_out, 64'd0);
        check("t8_busy", voice_busy, 64'd0);
        check("t8_addr", rom_addr, 64'd0);
        model_clear();
        tick(2);
        reset = 1'b1;
        enable = 1'b1;
        audio_out_allowed = 1'b1;
        mark = n_writes;
        tick(60);
        check("t8_silent", n_writes - mark, 64'd0);
        check("t8_busy_idle", voice_busy, 64'd0);
        quiesce_press(4'b0100);
        run_frames(10, 1);
        check("t8_resume_busy", voice_busy, 64'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
